seg7_scan_driver: RTL

Parametrised, time-multiplexed driver for a bank of common-anode or common-cathode 7-segment digits. It succeeds the single-digit combinational lookup: full hex 0–F decode, DIGITS channels scanned from one shared segment bus, and per-digit decimal point and blanking. Display data is double-buffered and committed only at frame boundaries, so the display never tears. It sits between the system's value registers (counters, traffic-light timers) and the board display pins.

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_hex_dec.sv | 15 +
 rtl/seg7_scan_driver.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg -- shared constants for the 7-segment scan driver.
//
// Contents:
//   SEG_A..SEG_G  bit positions of each segment in the 7-bit pattern
//   HEX_LUT       16-entry active-high hex glyph table (0-9, A, b, C, d, E, F)
//   hex_pattern() nibble -> active-high glyph lookup
//   SEG_BLANK     active-high pattern of a dark digit
package seg7_pkg;

    localparam int SEG_A = 0;   // top
    localparam int SEG_B = 1;   // upper right
    localparam int SEG_C = 2;   // lower right
    localparam int SEG_D = 3;   // bottom
    localparam int SEG_E = 4;   // lower left
    localparam int SEG_F = 5;   // upper left
    localparam int SEG_G = 6;   // middle

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Every nibble value has a glyph, so the table is complete and needs no fallback.
    localparam logic [6:0] HEX_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex_pattern(input logic [3:0] nibble);
        return HEX_LUT[nibble];
    endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// seg7_hex_dec -- combinational hex nibble to 7-segment decoder.
//
// Ports:
//   i_nibble  in  4  hex value 0..F
//   o_seg     out 7  active-high segment pattern, bit0 = a ... bit6 = g
module seg7_hex_dec
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = hex_pattern(i_nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver -- time-multiplexed driver for DIGITS 7-segment digits.
//
// Display data is double-buffered: iLOAD fills the pending buffer, and the
// active buffer is refreshed only when the scan wraps from the last digit to
// digit 0, so a frame never shows a mix of old and new values.
//
// Ports:
//   iCLK    in  1         clock, rising edge
//   iRST    in  1         synchronous active-high reset
//   iLOAD   in  1         capture iDATA/iDP/iBLANK into the pending buffer
//   iDATA   in  4*DIGITS  nibble k drives digit k (digit 0 rightmost)
//   iDP     in  DIGITS    decimal point per digit, 1 = lit
//   iBLANK  in  DIGITS    1 = digit fully dark (segments and DP)
//   oSEG    out 7         segment bus, polarity set by SEG_ACTIVE_LOW
//   oDP     out 1         decimal-point segment, polarity set by SEG_ACTIVE_LOW
//   oDIG    out DIGITS    one-hot digit select, polarity set by DIG_ACTIVE_LOW
//   oFRAME  out 1         one-cycle pulse when digit 0 becomes selected
//
// Optional build macro: SEG7_LZB_EN enables leading-zero blanking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iLOAD,
    input  logic [4*DIGITS-1:0]   iDATA,
    input  logic [DIGITS-1:0]     iDP,
    input  logic [DIGITS-1:0]     iBLANK,
    output logic [6:0]            oSEG,
    output logic                  oDP,
    output logic [DIGITS-1:0]     oDIG,
    output logic                  oFRAME
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);

    // XOR masks turning active-high values into pin levels.
    localparam logic [6:0]        SEG_POL = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_POL  = (SEG_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] DIG_POL = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

    logic [DIV_W-1:0]    r_div;
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_pend_data, r_act_data;
    logic [DIGITS-1:0]   r_pend_dp,   r_act_dp;
    logic [DIGITS-1:0]   r_pend_blank, r_act_blank;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic [DIGITS-1:0]   r_dig;
    logic                r_frame;

    logic                w_tc;
    logic                w_wrap;
    logic [IDX_W-1:0]    w_next_idx;
    logic [4*DIGITS-1:0] w_commit_data, w_next_data;
    logic [DIGITS-1:0]   w_commit_dp,   w_next_dp;
    logic [DIGITS-1:0]   w_commit_blank, w_next_blank;
    logic [DIGITS-1:0]   w_lz_blank;
    logic [DIGITS-1:0]   w_eff_blank;
    logic [3:0]          w_sel_nib;
    logic                w_sel_dp;
    logic                w_sel_blank;
    logic [6:0]          w_dec_seg;
    logic [6:0]          w_seg_ah;
    logic                w_dp_ah;
    logic [DIGITS-1:0]   w_dig_ah;

    assign w_tc       = (r_div == DIV_LAST);
    assign w_wrap     = w_tc && (r_idx == IDX_LAST);
    assign w_next_idx = w_wrap ? '0 : r_idx + 1'b1;

    // A load landing on the wrap cycle bypasses pend so it shows in the new frame.
    assign w_commit_data  = iLOAD ? iDATA  : r_pend_data;
    assign w_commit_dp    = iLOAD ? iDP    : r_pend_dp;
    assign w_commit_blank = iLOAD ? iBLANK : r_pend_blank;

    // Output registers are loaded from the buffer contents as they will be
    // after this edge, so the new frame's first digit is already correct.
    assign w_next_data  = w_wrap ? w_commit_data  : r_act_data;
    assign w_next_dp    = w_wrap ? w_commit_dp    : r_act_dp;
    assign w_next_blank = w_wrap ? w_commit_blank : r_act_blank;

`ifdef SEG7_LZB_EN
    // w_zero_from[k]: nibble k and every nibble above it are zero.
    logic [DIGITS-1:0] w_zero_from;
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lzb
        if (gi == DIGITS - 1) begin : g_top
            assign w_zero_from[gi] = (w_next_data[4*gi +: 4] == 4'h0);
        end else begin : g_rest
            assign w_zero_from[gi] = (w_next_data[4*gi +: 4] == 4'h0) && w_zero_from[gi+1];
        end
        if (gi == 0) begin : g_d0
            // Digit 0 always shows, so a zero value reads "0" rather than nothing.
            assign w_lz_blank[gi] = 1'b0;
        end else begin : g_dn
            assign w_lz_blank[gi] = w_zero_from[gi] && !w_next_dp[gi];
        end
    end
`else
    assign w_lz_blank = '0;
`endif

    assign w_eff_blank = w_next_blank | w_lz_blank;

    always_comb begin
        w_sel_nib   = 4'h0;
        w_sel_dp    = 1'b0;
        w_sel_blank = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (w_next_idx == IDX_W'(k)) begin
                w_sel_nib   = w_next_data[4*k +: 4];
                w_sel_dp    = w_next_dp[k];
                w_sel_blank = w_eff_blank[k];
            end
        end
    end

    seg7_hex_dec u_dec (
        .i_nibble (w_sel_nib),
        .o_seg    (w_dec_seg)
    );

    assign w_seg_ah = w_sel_blank ? SEG_BLANK : w_dec_seg;
    assign w_dp_ah  = w_sel_dp && !w_sel_blank;
    assign w_dig_ah = DIGITS'(1) << w_next_idx;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_div        <= '0;
            r_idx        <= '0;
            r_pend_data  <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '1;
            r_act_data   <= '0;
            r_act_dp     <= '0;
            r_act_blank  <= '1;
            r_seg        <= SEG_POL ^ SEG_BLANK;
            r_dp         <= DP_POL;
            r_dig        <= DIG_POL ^ DIGITS'(1);
            r_frame      <= 1'b0;
        end else begin
            r_div   <= w_tc ? '0 : r_div + 1'b1;
            r_frame <= w_wrap;
            if (iLOAD) begin
                r_pend_data  <= iDATA;
                r_pend_dp    <= iDP;
                r_pend_blank <= iBLANK;
            end
            if (w_wrap) begin
                r_act_data  <= w_commit_data;
                r_act_dp    <= w_commit_dp;
                r_act_blank <= w_commit_blank;
            end
            if (w_tc) begin
                r_idx <= w_next_idx;
                r_seg <= SEG_POL ^ w_seg_ah;
                r_dp  <= DP_POL ^ w_dp_ah;
                r_dig <= DIG_POL ^ w_dig_ah;
            end
        end
    end

    assign oSEG   = r_seg;
    assign oDP    = r_dp;
    assign oDIG   = r_dig;
    assign oFRAME = r_frame;

endmodule
